// File: rtl/alu_mul_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_seq_if
// Description : Request/response bundle between the accumulator datapath and
//               the sequential multiplier (start/busy/done handshake).
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_mul_seq_if #(
    parameter int N = 8
);
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;
    logic           hi_nz;

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  product,
        input  hi_nz
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output product,
        output hi_nz
    );
endinterface
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_seq
// Description : Unsigned NxN -> 2N shift-and-add multiplier that borrows one
//               external N-bit ripple ALU, one add per multiplier bit.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_seq #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    alu_mul_seq_if.slave      bus,
    output logic [N-1:0]      alu_in0,
    output logic [N-1:0]      alu_in1,
    output logic [2:0]        alu_ctrl,
    output logic              alu_cin,
    input  wire logic [N-1:0] alu_out,
    input  wire logic         alu_cout,
    input  wire logic         alu_v
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0]    C_ALU_ADD = 3'b000;
    localparam logic [CW-1:0] C_LAST    = CW'(N - 1);
    localparam logic [CW-1:0] C_ONE     = CW'(1);

    state_t           r_state;
    state_t           w_next_state;
    logic             w_load;
    logic             w_last;

    logic [N-1:0]     r_mcand;
    logic [N-1:0]     r_phi;
    logic [N-1:0]     r_plo;
    logic [CW-1:0]    r_cnt;
    logic [2*N-1:0]   r_product;
    logic             r_hi_nz;

    // Overflow flag is meaningless for an unsigned product.
    logic             w_unused_alu_v;
    assign w_unused_alu_v = alu_v;

    assign w_last = (r_cnt == C_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_load       = 1'b1;
                    w_next_state = ST_ITER;
                end
            end
            ST_ITER: begin
                bus.busy = 1'b1;
                if (w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.done = 1'b1;
                // A start seen here is accepted directly for back-to-back use.
                if (bus.start) begin
                    w_load       = 1'b1;
                    w_next_state = ST_ITER;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // ALU drive: accumulate phi + (multiplier LSB ? mcand : 0)
    // ------------------------------------------------------------------
    always_comb begin
        alu_ctrl = C_ALU_ADD;
        alu_cin  = 1'b0;
        alu_in0  = r_phi;
        alu_in1  = '0;
        if ((r_state == ST_ITER) && r_plo[0]) begin
            alu_in1 = r_mcand;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand   <= '0;
            r_phi     <= '0;
            r_plo     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
            r_hi_nz   <= 1'b0;
        end else begin
            if (w_load) begin
                r_mcand <= bus.a;
                r_plo   <= bus.b;
                r_phi   <= '0;
                r_cnt   <= '0;
            end else if (r_state == ST_ITER) begin
                // Carry-out becomes the new MSB so no product bit is lost.
                {r_phi, r_plo} <= {alu_cout, alu_out, r_plo[N-1:1]};
                r_cnt          <= r_cnt + C_ONE;
            end

            if (r_state == ST_DONE) begin
                r_product <= {r_phi, r_plo};
                r_hi_nz   <= |r_phi;
            end
        end
    end

    assign bus.product = r_product;
    assign bus.hi_nz   = r_hi_nz;

endmodule
`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_mul_seq
// Description : Directed self-checking bench for alu_mul_seq with a behavioural
//               ripple-ALU stand-in.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mul_seq;

    localparam int N  = 8;
    localparam int CW = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] alu_in0;
    logic [N-1:0] alu_in1;
    logic [2:0]   alu_ctrl;
    logic         alu_cin;
    logic [N-1:0] alu_out;
    logic         alu_cout;
    logic         alu_v;

    int total = 0;
    int bad   = 0;

    alu_mul_seq_if #(.N(N)) bus ();

    alu_mul_seq #(.N(N), .CW(CW)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .alu_in0  (alu_in0),
        .alu_in1  (alu_in1),
        .alu_ctrl (alu_ctrl),
        .alu_cin  (alu_cin),
        .alu_out  (alu_out),
        .alu_cout (alu_cout),
        .alu_v    (alu_v)
    );

    always #5 clk = ~clk;

    // Behavioural N-bit ALU: ADD and SUB only.
    always_comb begin
        logic [N:0] sum;
        sum = '0;
        if (alu_ctrl == 3'b001) begin
            sum = {1'b0, alu_in0} + {1'b0, ~alu_in1} + {{N{1'b0}}, 1'b1};
        end else begin
            sum = {1'b0, alu_in0} + {1'b0, alu_in1} + {{N{1'b0}}, alu_cin};
        end
        alu_out  = sum[N-1:0];
        alu_cout = sum[N];
        alu_v    = (alu_in0[N-1] == alu_in1[N-1]) && (sum[N-1] != alu_in0[N-1]);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One start pulse, wait for done, return product seen the cycle after done.
    task automatic do_mul(input logic [7:0] x, input logic [7:0] y,
                          output logic [15:0] p, output logic hn, output int lat);
        bus.a     = x;
        bus.b     = y;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 20) begin
            tick();
            lat++;
        end
        tick();
        p  = bus.product;
        hn = bus.hi_nz;
    endtask

    initial begin
        logic [15:0] p;
        logic        hn;
        int          lat;
        int          dn;
        logic [7:0]  xa, xb, pa, pb;
        logic [15:0] ep;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        tick();
        tick();
        chk("rst_busy",    32'(bus.busy),    32'd0);
        chk("rst_done",    32'(bus.done),    32'd0);
        chk("rst_product", 32'(bus.product), 32'd0);
        chk("rst_hi_nz",   32'(bus.hi_nz),   32'd0);
        rst = 1'b0;
        tick();

        // 1: 13 x 11, cycle-by-cycle
        bus.a = 8'd13; bus.b = 8'd11; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t1_busy", 32'(bus.busy), 32'd1);
            chk("t1_nodone", 32'(bus.done), 32'd0);
            tick();
        end
        chk("t1_done",     32'(bus.done),    32'd1);
        chk("t1_busy_off", 32'(bus.busy),    32'd0);
        chk("t1_old_prod", 32'(bus.product), 32'd0);
        tick();
        chk("t1_product",  32'(bus.product), 32'd143);
        chk("t1_hi_nz",    32'(bus.hi_nz),   32'd0);
        chk("t1_done_off", 32'(bus.done),    32'd0);
        chk("t1_idle_in1", 32'(alu_in1),     32'd0);

        // 2: FF x FF, watch ALU drive every iteration
        bus.a = 8'hFF; bus.b = 8'hFF; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t2_ctrl", 32'(alu_ctrl), 32'd0);
            chk("t2_cin",  32'(alu_cin),  32'd0);
            chk("t2_in1",  32'(alu_in1),  32'hFF);
            tick();
        end
        chk("t2_done", 32'(bus.done), 32'd1);
        tick();
        chk("t2_product", 32'(bus.product), 32'hFE01);
        chk("t2_hi_nz",   32'(bus.hi_nz),   32'd1);

        // 3: zero operands still take the full iteration count
        do_mul(8'h00, 8'hA5, p, hn, lat);
        chk("t3a_lat", 32'(lat), 32'd8);
        chk("t3a_product", 32'(p), 32'd0);
        chk("t3a_hi_nz", 32'(hn), 32'd0);
        do_mul(8'h5A, 8'h00, p, hn, lat);
        chk("t3b_lat", 32'(lat), 32'd8);
        chk("t3b_product", 32'(p), 32'd0);
        chk("t3b_hi_nz", 32'(hn), 32'd0);

        // 4: start held during busy is ignored; start in DONE is accepted
        bus.a = 8'd7; bus.b = 8'd9; bus.start = 1'b1;
        tick();
        bus.a = 8'd3; bus.b = 8'd3;
        dn = 0;
        for (int i = 0; i < 7; i++) begin
            if (bus.done) dn++;
            chk("t4_busy", 32'(bus.busy), 32'd1);
            tick();
        end
        bus.start = 1'b0;
        tick();
        chk("t4_done", 32'(bus.done), 32'd1);
        chk("t4_single_done", 32'(dn), 32'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("t4_b2b_busy", 32'(bus.busy), 32'd1);
        chk("t4_product", 32'(bus.product), 32'd63);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("t4_hold", 32'(bus.product), 32'd63);
        end
        tick();
        chk("t4_done2", 32'(bus.done), 32'd1);
        chk("t4_hold_done", 32'(bus.product), 32'd63);
        tick();
        chk("t4_product2", 32'(bus.product), 32'd9);
        chk("t4_idle", 32'(bus.done | bus.busy), 32'd0);

        // 5: asynchronous reset mid-operation
        bus.a = 8'd200; bus.b = 8'd200; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        #1;
        chk("t5_busy", 32'(bus.busy), 32'd0);
        chk("t5_done", 32'(bus.done), 32'd0);
        chk("t5_product", 32'(bus.product), 32'd0);
        tick();
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done) dn++;
            tick();
        end
        chk("t5_no_done", 32'(dn), 32'd0);
        do_mul(8'd2, 8'd3, p, hn, lat);
        chk("t5_product2", 32'(p), 32'd6);

        // 6: back-to-back random pairs with start held
        xa = 8'($urandom); xb = 8'($urandom);
        bus.a = xa; bus.b = xb; bus.start = 1'b1;
        tick();
        for (int i = 0; i < 500; i++) begin
            pa = xa; pb = xb;
            lat = 0;
            while (!bus.done && lat < 20) begin
                tick();
                lat++;
            end
            chk("t6_spacing", 32'(lat), 32'd8);
            xa = 8'($urandom); xb = 8'($urandom);
            bus.a = xa; bus.b = xb;
            bus.start = (i < 499);
            tick();
            ep = 16'(pa) * 16'(pb);
            chk("t6_product", 32'(bus.product), 32'(ep));
            chk("t6_hi_nz", 32'(bus.hi_nz), 32'(ep > 16'd255));
        end
        bus.start = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
